// File: rtl/call_stack.sv
// call_stack: hardware return-address stack for CALL/RET.
// Holds DEPTH entries of WIDTH bits behind a stack pointer that also
// serves as the entry count. Overflow and underflow set a sticky error
// flag that only reset clears. The top-of-stack output is decoded from
// registered state only, so Input never reaches Output in the same cycle.
//
// Handshake: push and pop are single-cycle strobes sampled on every
// rising clk edge. There is no ready. Requests that cannot be honoured
// (push while full, pop while empty) are dropped and flag error.
//
// Reset: rst is asynchronous and active-low. Assertion clears sp and
// error at once. Release passes through a two-flop synchroniser, so
// the stack starts taking requests on the third clk edge after rst
// rises. No partial update can happen on the release edge.
module call_stack #(
  parameter int UUID  = 0,
  parameter     NAME  = "",
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] Input,
  output logic [WIDTH-1:0] Output,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic             error
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [1:0]       rst_sync_q;
  logic             rst_int_n;
  logic [CW-1:0]    sp_q;
  logic [CW-1:0]    sp_d;
  logic             error_q;
  logic             error_d;
  logic             wr_en;
  logic [CW-1:0]    wr_idx;
  logic [CW-1:0]    top_idx;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Reset synchroniser: assert asynchronously, release after two clk edges
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync_q[1];

  // Flags and top-of-stack index are decoded from the registered pointer
  assign full    = (sp_q == CW'(DEPTH));
  assign empty   = (sp_q == '0);
  assign count   = sp_q;
  assign error   = error_q;
  assign top_idx = sp_q - CW'(1);

  // Storage write decode: push+pop on a non-empty stack replaces the top entry
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = sp_q;
    if (rst_int_n) begin
      if (push && pop && !empty) begin
        wr_en  = 1'b1;
        wr_idx = top_idx;
      end else if (push && !full) begin
        wr_en  = 1'b1;
        wr_idx = sp_q;
      end
    end
  end

  // Next pointer and sticky error; sp saturates inside 0..DEPTH
  always_comb begin
    sp_d    = sp_q;
    error_d = error_q;
    if (push && pop) begin
      if (empty) begin
        sp_d = sp_q + CW'(1);
      end
    end else if (push) begin
      if (full) begin
        error_d = 1'b1;
      end else begin
        sp_d = sp_q + CW'(1);
      end
    end else if (pop) begin
      if (empty) begin
        error_d = 1'b1;
      end else begin
        sp_d = sp_q - CW'(1);
      end
    end
  end

  // Pointer and error registers, cleared asynchronously by reset
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      sp_q    <= '0;
      error_q <= 1'b0;
    end else begin
      sp_q    <= sp_d;
      error_q <= error_d;
    end
  end

  // Entry storage; contents are not reset because empty masks them
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx[AW-1:0]] <= Input;
    end
  end

  // Top-of-stack read, zero when the stack holds nothing
  always_comb begin
    Output = '0;
    if (!empty) begin
      Output = mem_q[top_idx[AW-1:0]];
    end
  end

endmodule
